// File: rtl/mux_n_scan.sv
// rtl/mux_n_scan.sv - N-channel registered mux, manual select or round-robin scan with valid/ready output.
// Optional MUX_MASK_EN adds the ch_en per-channel enable port.
module mux_n_scan #(
  parameter int N     = 4,
  parameter int WIDTH = 1,
  parameter int DWELL = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N*WIDTH-1:0] din,
`ifdef MUX_MASK_EN
  input  logic [N-1:0]       ch_en,
`endif
  output logic [WIDTH-1:0]   dout,
  output logic [SW-1:0]      dout_ch,
  output logic               dout_valid,
  input  logic               dout_ready
);
  localparam int CW = $clog2(DWELL + 1);
  localparam int NP = 2 ** SW;

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [SW-1:0]    r_ptr, w_ptr_nxt, w_ptr_cur, w_ptr_first, w_ptr_adv;
  logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_cur;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic [SW-1:0]    r_dout_ch, w_dout_ch_nxt;
  logic             r_valid, w_valid_nxt;
  logic             w_ld, w_entry, w_any_en;
  logic [WIDTH-1:0] w_ch [NP];
  logic [NP-1:0]    w_en;
  logic [N-1:0]     w_en_raw;

`ifdef MUX_MASK_EN
  assign w_en_raw = ch_en;
`else
  assign w_en_raw = '1;
`endif

  // Out-of-range selects (non power-of-2 N) read as an enabled all-zero channel.
  for (genvar k = 0; k < NP; k++) begin : g_pad
    if (k < N) begin : g_in
      assign w_ch[k] = din[k*WIDTH +: WIDTH];
      assign w_en[k] = w_en_raw[k];
    end else begin : g_out
      assign w_ch[k] = '0;
      assign w_en[k] = 1'b1;
    end
  end

  assign w_any_en  = |w_en_raw;
  assign w_ld      = !r_valid || dout_ready;
  assign w_entry   = (r_state == MANUAL) && mode;
  assign w_ptr_cur = w_entry ? w_ptr_first : r_ptr;
  assign w_cnt_cur = w_entry ? '0 : r_cnt;

`ifdef MUX_MASK_EN
  logic [SW:0] w_sum;

  always_comb begin
    w_ptr_first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_en[SW'(i)]) w_ptr_first = SW'(i);
    end
  end

  // Downward search so the nearest enabled channel after the pointer wins.
  always_comb begin
    w_ptr_adv = w_ptr_cur;
    w_sum     = '0;
    for (int i = N - 1; i >= 1; i--) begin
      w_sum = {1'b0, w_ptr_cur} + (SW+1)'(i);
      if (w_sum >= (SW+1)'(N)) w_sum = w_sum - (SW+1)'(N);
      if (w_en[w_sum[SW-1:0]]) w_ptr_adv = w_sum[SW-1:0];
    end
  end
`else
  assign w_ptr_first = '0;
  assign w_ptr_adv   = (w_ptr_cur == SW'(N - 1)) ? '0 : w_ptr_cur + SW'(1);
`endif

  always_comb begin
    w_state_nxt   = mode ? SCAN : MANUAL;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_dout_nxt    = r_dout;
    w_dout_ch_nxt = r_dout_ch;
    w_valid_nxt   = r_valid;
    if (mode) begin
      w_ptr_nxt = w_ptr_cur;
      w_cnt_nxt = w_cnt_cur;
      if (w_ld) begin
        if (w_any_en) begin
          w_dout_nxt    = w_ch[w_ptr_cur];
          w_dout_ch_nxt = w_ptr_cur;
          w_valid_nxt   = 1'b1;
          if (w_cnt_cur == CW'(DWELL - 1)) begin
            w_cnt_nxt = '0;
            w_ptr_nxt = w_ptr_adv;
          end else begin
            w_cnt_nxt = w_cnt_cur + CW'(1);
          end
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
    end else if (w_ld) begin
      if (w_en[sel]) begin
        w_dout_nxt    = w_ch[sel];
        w_dout_ch_nxt = sel;
        w_valid_nxt   = 1'b1;
      end else begin
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= MANUAL;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_dout_ch <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dout    <= w_dout_nxt;
      r_dout_ch <= w_dout_ch_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_ch    = r_dout_ch;
  assign dout_valid = r_valid;
endmodule

// File: tb/tb_mux_n_scan.sv
// tb/tb_mux_n_scan.sv - self-checking bench for mux_n_scan: directed scenarios plus randomized traffic vs a load-count model.
module tb_mux_n_scan;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int DWELL = 2;
  localparam int SW    = 2;

  logic               clk = 1'b0;
  logic               rst, mode, dout_ready, dout_valid;
  logic [SW-1:0]      sel, dout_ch;
  logic [N*WIDTH-1:0] din;
  logic [WIDTH-1:0]   dout;
  logic [N-1:0]       ch_en;

  int checks = 0;
  int errors = 0;

  logic             m_scan;
  int               m_loads;
  int               m_list[$];
  logic [WIDTH-1:0] e_dout;
  logic [SW-1:0]    e_ch;
  logic             e_valid;

  always #5 clk = ~clk;

  mux_n_scan #(.N(N), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .sel        (sel),
    .din        (din),
`ifdef MUX_MASK_EN
    .ch_en      (ch_en),
`endif
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scan model: the k-th accepted sample since scan entry belongs to enabled channel (k / DWELL) mod count.
  task automatic model_step();
    logic ld;
    int   idx;
    ld = !e_valid || dout_ready;
    if (rst) begin
      e_dout = '0; e_ch = '0; e_valid = 1'b0; m_scan = 1'b0; m_loads = 0;
      return;
    end
    if (mode) begin
      if (!m_scan) begin
        m_loads = 0;
        m_list.delete();
        for (int k = 0; k < N; k++) if (ch_en[k]) m_list.push_back(k);
      end
      if (ld) begin
        if (ch_en == '0 || m_list.size() == 0) begin
          e_valid = 1'b0;
        end else begin
          idx     = m_list[(m_loads / DWELL) % m_list.size()];
          e_dout  = din[idx*WIDTH +: WIDTH];
          e_ch    = SW'(idx);
          e_valid = 1'b1;
          m_loads++;
        end
      end
    end else if (ld) begin
      if (ch_en[sel]) begin
        e_dout  = din[int'(sel)*WIDTH +: WIDTH];
        e_ch    = sel;
        e_valid = 1'b1;
      end else begin
        e_valid = 1'b0;
      end
    end
    m_scan = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_dout", 32'(dout), 32'(e_dout));
    check("model_ch", 32'(dout_ch), 32'(e_ch));
    check("model_valid", 32'(dout_valid), 32'(e_valid));
  endtask

  task automatic expect_out(input string tag, input int ch, input int d, input logic v);
    check({tag, "_ch"}, 32'(dout_ch), 32'(ch));
    check({tag, "_dout"}, 32'(dout), 32'(d));
    check({tag, "_valid"}, 32'(dout_valid), 32'(v));
  endtask

  initial begin
    int seq_ch[9];
    int seq_d[9];
    seq_ch = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    seq_d  = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h44, 'h44, 'h11};
    rst = 1'b1; mode = 1'b0; sel = '0; dout_ready = 1'b1; ch_en = '1;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    e_dout = '0; e_ch = '0; e_valid = 1'b0; m_scan = 1'b0; m_loads = 0;

    tick(); tick();
    expect_out("reset", 0, 0, 1'b0);

    rst = 1'b0; sel = 2'd2;
    tick(); expect_out("man_sel2", 2, 'h33, 1'b1);
    sel = 2'd3;
    tick(); expect_out("man_sel3", 3, 'h44, 1'b1);

    mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(); expect_out($sformatf("scan%0d", i), seq_ch[i], seq_d[i], 1'b1);
    end

    tick(); tick(); tick();
    expect_out("pre_stall", 1, 'h22, 1'b1);
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = {$urandom, $urandom} & 32'hffff_ffff;
      tick(); expect_out($sformatf("stall%0d", i), 1, 'h22, 1'b1);
    end
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    dout_ready = 1'b1;
    tick(); expect_out("resume0", 2, 'h33, 1'b1);
    tick(); expect_out("resume1", 2, 'h33, 1'b1);

    rst = 1'b1;
    tick(); expect_out("mid_rst", 0, 0, 1'b0);
    rst = 1'b0;
    tick(); expect_out("restart0", 0, 'h11, 1'b1);
    tick(); expect_out("restart1", 0, 'h11, 1'b1);
    tick(); expect_out("restart2", 1, 'h22, 1'b1);

`ifdef MUX_MASK_EN
    mode = 1'b0; sel = 2'd0;
    tick();
    ch_en = 4'b1010; mode = 1'b1;
    tick(); expect_out("mask0", 1, 'h22, 1'b1);
    tick(); expect_out("mask1", 1, 'h22, 1'b1);
    tick(); expect_out("mask2", 3, 'h44, 1'b1);
    tick(); expect_out("mask3", 3, 'h44, 1'b1);
    tick(); expect_out("mask4", 1, 'h22, 1'b1);
    ch_en = '0;
    tick(); check("mask_none_valid", 32'(dout_valid), 32'd0);
    mode = 1'b0; ch_en = 4'b1110; sel = 2'd1;
    tick(); expect_out("mask_man1", 1, 'h22, 1'b1);
    sel = 2'd0;
    tick(); check("mask_man0_valid", 32'(dout_valid), 32'd0);
`endif

    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      sel        = SW'($urandom_range(0, N - 1));
      din        = {$urandom, $urandom} & 32'hffff_ffff;
      if ($urandom_range(0, 14) == 0) mode = ~mode;
`ifdef MUX_MASK_EN
      if (!mode && $urandom_range(0, 3) == 0) ch_en = N'($urandom_range(0, 2**N - 1));
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
